// File: rtl/param_sync_fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Status struct, interrupt bit positions and the non-power-of-2 pointer wrap.
package param_sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Bit positions inside IRQ_EN and the interrupt source vector
  localparam int IRQ_AE  = 0;
  localparam int IRQ_AF  = 1;
  localparam int IRQ_OVF = 2;
  localparam int IRQ_UDF = 3;

  // Wrap by explicit compare so any depth works, not only powers of two
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr == depth - 1) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Bus bundle between a FIFO producer/consumer (master) and the FIFO (slave).
// Handshake: a write lands when WR_EN is high and the FIFO is not full (or a read pops the same cycle); a read is taken when RD_EN is high and the FIFO is not empty, with RD_DATA/RD_VALID one edge later.
interface param_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 15
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              WR_EN;
  logic [DATA_W-1:0] WR_DATA;
  logic              RD_EN;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              FLUSH;
  logic [CNT_W-1:0]  AF_THRESH;
  logic [CNT_W-1:0]  AE_THRESH;
  logic              CLR_ERR;
  logic [3:0]        IRQ_EN;
  logic              FULL;
  logic              EMPTY;
  logic              ALMOST_FULL;
  logic              ALMOST_EMPTY;
  logic [CNT_W-1:0]  COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic              INTR;
  logic [2*PTR_W-1:0] DBG_POS;

  modport master (
    output WR_EN, WR_DATA, RD_EN, FLUSH, AF_THRESH, AE_THRESH, CLR_ERR, IRQ_EN,
    input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
           OVERFLOW, UNDERFLOW, INTR, DBG_POS
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_EN, FLUSH, AF_THRESH, AE_THRESH, CLR_ERR, IRQ_EN,
    output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
           OVERFLOW, UNDERFLOW, INTR, DBG_POS
  );

endinterface

// File: rtl/param_sync_fifo_ram.sv
// DEPTH x DATA_W storage with one write port and a registered read port.
// The array itself is never reset so it maps onto distributed RAM; only the read register is.
module param_sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 15,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [PTR_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [PTR_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write on a shared address: a full FIFO reading and writing the same slot returns the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO: pointer/count control, registered flags,
// sticky overflow/underflow, maskable interrupt and a {rd_ptr, wr_ptr} debug bus.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 15
) (
  input  logic CLK100,
  input  logic RESETN,
  param_sync_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_intr;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ram_wr;
  logic              w_ram_rd;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_ovf_nxt;
  logic              w_udf_nxt;
  logic              w_af;
  logic              w_ae;
  logic [3:0]        w_irq_src;
  logic [DATA_W-1:0] w_rd_data;
  fifo_status_t      w_status;

  // A full FIFO may still take a write when a read frees the slot the same cycle
  assign w_rd_acc = bus.RD_EN & ~r_empty;
  assign w_wr_acc = bus.WR_EN & (~r_full | w_rd_acc);
  assign w_ram_wr = w_wr_acc & ~bus.FLUSH;
  assign w_ram_rd = w_rd_acc & ~bus.FLUSH;

  assign w_af = (r_count >= bus.AF_THRESH);
  assign w_ae = (r_count <= bus.AE_THRESH);

  always_comb begin
    w_count_nxt = r_count;
    if (bus.FLUSH) begin
      w_count_nxt = '0;
    end else if (w_ram_wr && !w_ram_rd) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_ram_wr && w_ram_rd) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Flush is a deliberate clear, so requests rejected during it are not errors; a new error beats CLR_ERR
  always_comb begin
    w_ovf_nxt = r_overflow & ~bus.CLR_ERR;
    w_udf_nxt = r_underflow & ~bus.CLR_ERR;
    if (bus.WR_EN && !w_wr_acc && !bus.FLUSH) begin
      w_ovf_nxt = 1'b1;
    end
    if (bus.RD_EN && !w_rd_acc && !bus.FLUSH) begin
      w_udf_nxt = 1'b1;
    end
  end

  always_comb begin
    w_irq_src          = '0;
    w_irq_src[IRQ_AE]  = w_ae;
    w_irq_src[IRQ_AF]  = w_af;
    w_irq_src[IRQ_OVF] = r_overflow;
    w_irq_src[IRQ_UDF] = r_underflow;
  end

  always_ff @(posedge CLK100 or negedge RESETN) begin
    if (!RESETN) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_intr      <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      r_rd_valid  <= w_ram_rd;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_udf_nxt;
      r_intr      <= |(bus.IRQ_EN & w_irq_src);
      if (bus.FLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_ram_wr) begin
          r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
        end
        if (w_ram_rd) begin
          r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
        end
      end
    end
  end

  param_sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk       (CLK100),
    .rst_n     (RESETN),
    .i_wr_en   (w_ram_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.WR_DATA),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign w_status = '{
    full:         r_full,
    empty:        r_empty,
    almost_full:  w_af,
    almost_empty: w_ae,
    overflow:     r_overflow,
    underflow:    r_underflow
  };

  assign bus.RD_DATA      = w_rd_data;
  assign bus.RD_VALID     = r_rd_valid;
  assign bus.FULL         = w_status.full;
  assign bus.EMPTY        = w_status.empty;
  assign bus.ALMOST_FULL  = w_status.almost_full;
  assign bus.ALMOST_EMPTY = w_status.almost_empty;
  assign bus.COUNT        = r_count;
  assign bus.OVERFLOW     = w_status.overflow;
  assign bus.UNDERFLOW    = w_status.underflow;
  assign bus.INTR         = r_intr;
  assign bus.DBG_POS      = {r_rd_ptr, r_wr_ptr};

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a 15x8 instance for the main scenarios
// and a 16x32 instance repeating fill/overflow/drain and full-rate streaming.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst_n;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  int          m_wr;
  int          m_rd;
  int          g_wr;
  int          g_rd;
  logic [31:0] last_rd;
  logic [31:0] e;

  param_sync_fifo_if #(.DATA_W(8),  .DEPTH(15)) f ();
  param_sync_fifo_if #(.DATA_W(32), .DEPTH(16)) g ();

  param_sync_fifo #(.DATA_W(8), .DEPTH(15)) u_dut (
    .CLK100 (clk),
    .RESETN (rst_n),
    .bus    (f.slave)
  );

  param_sync_fifo #(.DATA_W(32), .DEPTH(16)) u_dut32 (
    .CLK100 (clk),
    .RESETN (rst_n),
    .bus    (g.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    f.WR_EN   = 1'b1;
    f.WR_DATA = d;
    if (exp_q.size() < 15) begin
      exp_q.push_back({24'h0, d});
      m_wr = (m_wr + 1) % 15;
    end
    cyc();
    f.WR_EN = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    f.RD_EN = 1'b1;
    cyc();
    f.RD_EN = 1'b0;
    e = exp_q.pop_front();
    m_rd = (m_rd + 1) % 15;
    last_rd = e;
    check({tag, "_valid"}, f.RD_VALID, 1);
    check({tag, "_data"}, f.RD_DATA, e);
  endtask

  initial begin
    rst_n = 1'b0;
    f.WR_EN = 0; f.RD_EN = 0; f.FLUSH = 0; f.CLR_ERR = 0; f.WR_DATA = '0;
    f.AF_THRESH = 5'd15; f.AE_THRESH = 5'd0; f.IRQ_EN = 4'b0000;
    g.WR_EN = 0; g.RD_EN = 0; g.FLUSH = 0; g.CLR_ERR = 0; g.WR_DATA = '0;
    g.AF_THRESH = 5'd16; g.AE_THRESH = 5'd0; g.IRQ_EN = 4'b0000;
    m_wr = 0; m_rd = 0; g_wr = 0; g_rd = 0; last_rd = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // reset state
    check("rst_count", f.COUNT, 0);
    check("rst_empty", f.EMPTY, 1);
    check("rst_full", f.FULL, 0);
    check("rst_rd_data", f.RD_DATA, 0);
    check("rst_rd_valid", f.RD_VALID, 0);
    check("rst_ovf", f.OVERFLOW, 0);
    check("rst_udf", f.UNDERFLOW, 0);
    check("rst_intr", f.INTR, 0);
    check("rst_dbg", f.DBG_POS, 0);

    // 1: fill, overflow, drain in order
    for (int i = 1; i <= 15; i++) push(8'(i));
    check("t1_count15", f.COUNT, 15);
    check("t1_full", f.FULL, 1);
    check("t1_no_ovf_yet", f.OVERFLOW, 0);
    check("t1_wr_wrap_dbg", f.DBG_POS, {4'(m_rd), 4'(m_wr)});
    push(8'h10);
    check("t1_ovf", f.OVERFLOW, 1);
    check("t1_count_hold", f.COUNT, 15);
    for (int i = 1; i <= 15; i++) pop_chk("t1_rd");
    cyc();
    check("t1_valid_drop", f.RD_VALID, 0);
    check("t1_empty", f.EMPTY, 1);
    check("t1_count0", f.COUNT, 0);

    // 2: read on empty with same-cycle write, no fall-through
    f.CLR_ERR = 1'b1; cyc(); f.CLR_ERR = 1'b0;
    check("t2_ovf_clr", f.OVERFLOW, 0);
    f.RD_EN = 1'b1; f.WR_EN = 1'b1; f.WR_DATA = 8'hAA;
    exp_q.push_back(32'hAA); m_wr = (m_wr + 1) % 15;
    cyc();
    f.RD_EN = 1'b0; f.WR_EN = 1'b0;
    check("t2_no_valid", f.RD_VALID, 0);
    check("t2_udf", f.UNDERFLOW, 1);
    check("t2_count1", f.COUNT, 1);
    check("t2_rd_hold", f.RD_DATA, 8'h0F);
    pop_chk("t2_rd");
    f.CLR_ERR = 1'b1; f.RD_EN = 1'b1; cyc();
    check("t2_set_wins", f.UNDERFLOW, 1);
    f.RD_EN = 1'b0; cyc(); f.CLR_ERR = 1'b0;
    check("t2_udf_clr", f.UNDERFLOW, 0);

    // 3: full-rate read+write while full
    for (int i = 0; i < 15; i++) push(8'h30 + 8'(i));
    f.RD_EN = 1'b1; f.WR_EN = 1'b1; f.WR_DATA = 8'h55;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      exp_q.push_back(32'h55);
      m_rd = (m_rd + 1) % 15;
      m_wr = (m_wr + 1) % 15;
      cyc();
      check("t3_data", f.RD_DATA, e);
      check("t3_count", f.COUNT, 15);
    end
    f.RD_EN = 1'b0; f.WR_EN = 1'b0;
    last_rd = e;
    check("t3_no_ovf", f.OVERFLOW, 0);
    check("t3_full", f.FULL, 1);
    check("t3_dbg", f.DBG_POS, {4'(m_rd), 4'(m_wr)});
    for (int i = 0; i < 15; i++) pop_chk("t3_drain");

    // 4: thresholds and interrupt
    f.AF_THRESH = 5'd12; f.AE_THRESH = 5'd3; f.IRQ_EN = 4'b0010;
    for (int i = 0; i < 11; i++) push(8'h80 + 8'(i));
    check("t4_af0", f.ALMOST_FULL, 0);
    check("t4_ae0", f.ALMOST_EMPTY, 0);
    check("t4_intr0", f.INTR, 0);
    push(8'h8B);
    check("t4_count12", f.COUNT, 12);
    check("t4_af1", f.ALMOST_FULL, 1);
    check("t4_intr_lag", f.INTR, 0);
    cyc();
    check("t4_intr1", f.INTR, 1);
    pop_chk("t4_rd");
    check("t4_af_clr", f.ALMOST_FULL, 0);
    check("t4_intr_hold", f.INTR, 1);
    cyc();
    check("t4_intr_drop", f.INTR, 0);
    for (int i = 0; i < 8; i++) pop_chk("t4_drain");
    check("t4_count3", f.COUNT, 3);
    check("t4_ae1", f.ALMOST_EMPTY, 1);
    check("t4_intr_masked", f.INTR, 0);
    f.IRQ_EN = 4'b0001; cyc();
    check("t4_intr_ae", f.INTR, 1);
    f.IRQ_EN = 4'b0000; cyc();
    check("t4_intr_off", f.INTR, 0);
    f.AF_THRESH = 5'd0; #1;
    check("t4_af_thr0", f.ALMOST_FULL, 1);
    f.AF_THRESH = 5'd15; #1;
    check("t4_af_thr15", f.ALMOST_FULL, 0);
    f.AE_THRESH = 5'd15; #1;
    check("t4_ae_thr15", f.ALMOST_EMPTY, 1);
    f.AE_THRESH = 5'd2; #1;
    check("t4_ae_thr2", f.ALMOST_EMPTY, 0);
    f.AE_THRESH = 5'd0;

    // 5: flush overrides same-cycle read/write
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    check("t5_count7", f.COUNT, 7);
    f.FLUSH = 1'b1; f.WR_EN = 1'b1; f.RD_EN = 1'b1; f.WR_DATA = 8'h77;
    cyc();
    f.FLUSH = 1'b0; f.WR_EN = 1'b0; f.RD_EN = 1'b0;
    exp_q.delete(); m_wr = 0; m_rd = 0;
    check("t5_count0", f.COUNT, 0);
    check("t5_empty", f.EMPTY, 1);
    check("t5_no_valid", f.RD_VALID, 0);
    check("t5_ovf", f.OVERFLOW, 0);
    check("t5_udf", f.UNDERFLOW, 0);
    check("t5_rd_hold", f.RD_DATA, last_rd);
    check("t5_dbg", f.DBG_POS, 0);
    cyc();
    check("t5_still0", f.COUNT, 0);

    // 6: asynchronous reset mid-burst
    f.AF_THRESH = 5'd5; f.IRQ_EN = 4'b0010;
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
    pop_chk("t6_rd");
    check("t6_count9", f.COUNT, 9);
    check("t6_intr_pre", f.INTR, 1);
    rst_n = 1'b0;
    #1;
    check("t6_count", f.COUNT, 0);
    check("t6_empty", f.EMPTY, 1);
    check("t6_full", f.FULL, 0);
    check("t6_valid", f.RD_VALID, 0);
    check("t6_rd_data", f.RD_DATA, 0);
    check("t6_intr", f.INTR, 0);
    check("t6_dbg", f.DBG_POS, 0);
    cyc();
    rst_n = 1'b1;
    exp_q.delete(); m_wr = 0; m_rd = 0;
    f.IRQ_EN = 4'b0000; f.AF_THRESH = 5'd15;
    cyc();
    push(8'h3C);
    pop_chk("t6_post");

    // 16x32 instance: fill, overflow, drain, full-rate streaming
    for (int i = 0; i < 16; i++) begin
      g.WR_EN = 1'b1; g.WR_DATA = 32'hA5A5_0000 + 32'(i);
      exp_q.push_back(g.WR_DATA); g_wr = (g_wr + 1) % 16;
      cyc();
    end
    g.WR_DATA = 32'hDEAD_BEEF;
    cyc();
    g.WR_EN = 1'b0;
    check("w_count16", g.COUNT, 16);
    check("w_full", g.FULL, 1);
    check("w_ovf", g.OVERFLOW, 1);
    check("w_dbg_wrap", g.DBG_POS, {4'(g_rd), 4'(g_wr)});
    for (int i = 0; i < 16; i++) begin
      g.RD_EN = 1'b1; cyc(); g.RD_EN = 1'b0;
      e = exp_q.pop_front(); g_rd = (g_rd + 1) % 16;
      check("w_rd_valid", g.RD_VALID, 1);
      check("w_rd_data", g.RD_DATA, e);
    end
    check("w_empty", g.EMPTY, 1);
    g.CLR_ERR = 1'b1; cyc(); g.CLR_ERR = 1'b0;
    check("w_ovf_clr", g.OVERFLOW, 0);
    for (int i = 0; i < 16; i++) begin
      g.WR_EN = 1'b1; g.WR_DATA = 32'h1234_5600 + 32'(i);
      exp_q.push_back(g.WR_DATA); g_wr = (g_wr + 1) % 16;
      cyc();
    end
    g.RD_EN = 1'b1; g.WR_DATA = 32'h5555_5555;
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      exp_q.push_back(32'h5555_5555);
      g_rd = (g_rd + 1) % 16;
      g_wr = (g_wr + 1) % 16;
      cyc();
      check("w_stream_data", g.RD_DATA, e);
    end
    g.RD_EN = 1'b0; g.WR_EN = 1'b0;
    check("w_stream_count", g.COUNT, 16);
    check("w_stream_ovf", g.OVERFLOW, 0);
    check("w_stream_dbg", g.DBG_POS, {4'(g_rd), 4'(g_wr)});

    // report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
